// File: rtl/clause_fetch.sv
// clause_fetch: read initiator for the synchronous-read clause/attribute
// memories. A start request sweeps `count` consecutive words from
// `base_addr`, absorbs the memory's one-cycle read latency in a 2-entry
// buffer and streams the words in order on a valid/ready interface.
module clause_fetch #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      count,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_read_en,
    input  logic [WIDTH-1:0] mem_data_i,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   LEFT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   LEFT_ONE  = (AW+1)'(1);

    // Next sequential read address; the top address wraps back to zero so
    // non-power-of-two depths sweep correctly as well.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        logic [AW-1:0] n;
        if (a == LAST_ADDR) begin
            n = {AW{1'b0}};
        end else begin
            n = a + AW'(1);
        end
        return n;
    endfunction

    // Control state
    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic [AW-1:0]   r_rd_addr;
    logic [AW:0]     r_rd_left;

    // Read-side tracking: one read may be in flight inside the memory
    logic            r_inflight;
    logic            r_inflight_last;
    logic [AW-1:0]   r_last_addr;

    // Two-entry FIFO holding captured words and their last flags
    logic [WIDTH-1:0] r_buf_data_0;
    logic [WIDTH-1:0] r_buf_data_1;
    logic             r_buf_last_0;
    logic             r_buf_last_1;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;

    // Combinational helpers
    logic             w_pop;
    logic             w_issue;
    logic             w_head_last;
    logic [WIDTH-1:0] w_head_data;
    logic [2:0]       w_slots_used;
    logic [2:0]       w_slots_limit;

    // Head-of-buffer selection and stream handshake decode
    always_comb begin
        w_head_data = r_buf_data_0;
        w_head_last = r_buf_last_0;
        if (r_rd_ptr) begin
            w_head_data = r_buf_data_1;
            w_head_last = r_buf_last_1;
        end else begin
            w_head_data = r_buf_data_0;
            w_head_last = r_buf_last_0;
        end
        w_pop = (r_occ != 2'd0) && out_ready;
    end

    // Issue a read only while words remain and the buffer can absorb the
    // result, counting the word in flight and any word leaving this cycle.
    always_comb begin
        w_slots_used  = {1'b0, r_occ} + {2'b00, r_inflight};
        w_slots_limit = 3'd2 + {2'b00, w_pop};
        w_issue       = 1'b0;
        if ((r_state == ST_FETCH) && (r_rd_left != LEFT_ZERO) &&
            (w_slots_used < w_slots_limit)) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    assign mem_read_en = w_issue;
    assign mem_addr    = w_issue ? r_rd_addr : r_last_addr;
    assign out_valid   = (r_occ != 2'd0);
    assign out_data    = w_head_data;
    assign out_last    = w_head_last;
    assign busy        = r_busy;
    assign done        = r_done;

    // Request FSM: sweep counters plus registered busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_addr <= {AW{1'b0}};
            r_rd_left <= LEFT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_rd_addr <= base_addr;
                        r_rd_left <= count;
                        if (count == LEFT_ZERO) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        r_rd_addr <= next_addr(r_rd_addr);
                        r_rd_left <= r_rd_left - LEFT_ONE;
                        if (r_rd_left == LEFT_ONE) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_head_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Track the read inside the memory and hold the last issued address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_last_addr     <= {AW{1'b0}};
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_left == LEFT_ONE);
            if (w_issue) begin
                r_last_addr <= r_rd_addr;
            end else begin
                r_last_addr <= r_last_addr;
            end
        end
    end

    // Buffer write side: capture returning memory data in issue order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_data_0 <= {WIDTH{1'b0}};
            r_buf_data_1 <= {WIDTH{1'b0}};
            r_buf_last_0 <= 1'b0;
            r_buf_last_1 <= 1'b0;
            r_wr_ptr     <= 1'b0;
        end else begin
            if (r_inflight) begin
                if (r_wr_ptr) begin
                    r_buf_data_1 <= mem_data_i;
                    r_buf_last_1 <= r_inflight_last;
                end else begin
                    r_buf_data_0 <= mem_data_i;
                    r_buf_last_0 <= r_inflight_last;
                end
                r_wr_ptr <= ~r_wr_ptr;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
        end
    end

    // Buffer read side and occupancy; capture and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_fetch.sv
// Self-checking bench for clause_fetch: a table of directed requests, hand
// sequences for reset abort, and randomized requests checked against a
// word-list reference model of the memory sweep.
module tb_clause_fetch;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      count;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_addr;
    logic             mem_read_en;
    logic [WIDTH-1:0] mem_data_i = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    always #5 clk = ~clk;

    clause_fetch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .busy(busy), .done(done), .mem_addr(mem_addr),
        .mem_read_en(mem_read_en), .mem_data_i(mem_data_i),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    // Registered-output memory model
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_read_en) mem_data_i <= mem[mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Observations of one request
    logic [32:0] q_words[$];
    int          q_addrs[$];
    int n_reads, n_done, done_cyc, max_out, stab_err, post_err, busy0, timed_out;

    typedef struct {
        int          base;
        int          cnt;
        int          mode;
        int          poke;
        int          exp_done;
        int          exp_busy0;
        logic [31:0] exp_first;
        logic [31:0] exp_lastw;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0: return 1'b1;
            1: if (c >= 2 && c <= 5) return 1'b0;
               else if (c >= 6) return (c % 2 == 0);
               else return 1'b1;
            2: return ($urandom_range(0, 3) != 0);
            3: return (c >= 8);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_req(input int base, input int cnt, input int mode, input int poke);
        int issued, popped;
        bit fin, prev_stall;
        logic [31:0] prev_data;
        logic prev_last;
        q_words.delete(); q_addrs.delete();
        n_reads = 0; n_done = 0; done_cyc = -1; max_out = 0; stab_err = 0;
        post_err = 0; busy0 = 0; timed_out = 0;
        issued = 0; popped = 0; fin = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); count = (AW+1)'(cnt); out_ready = 1'b1;
        @(posedge clk); #1;       // edge E0 has sampled start
        start = 1'b0;
        for (int c = 0; c < 150 && !fin; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == poke) begin
                start = 1'b1; base_addr = 3'd3; count = 4'd2;
            end else begin
                start = 1'b0;
            end
            out_ready = ready_for(mode, c);
            #1;
            if (c == 0) busy0 = busy;
            if (prev_stall && !(out_valid && out_data == prev_data && out_last == prev_last))
                stab_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (mem_read_en) begin
                n_reads++; issued++;
                q_addrs.push_back(int'(mem_addr));
            end
            if (out_valid && out_ready) begin
                q_words.push_back({out_last, out_data});
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (done_cyc >= 0) begin
                fin = 1;
                if (busy || out_valid || done) post_err++;
            end else if (done) begin
                done_cyc = c;
            end
            if (done) n_done++;
        end
        start = 1'b0;
        if (!fin) timed_out = 1;
    endtask

    // Reference model: the request yields mem[(base+k) mod DEPTH], k < cnt,
    // with the last flag only on the final word and one read per word.
    task automatic verify(input string tag, input int base, input int cnt);
        int nw;
        chk({tag, "/timeout"}, timed_out, 0);
        chk({tag, "/n_words"}, q_words.size(), cnt);
        nw = (q_words.size() < cnt) ? q_words.size() : cnt;
        for (int k = 0; k < nw; k++) begin
            chk($sformatf("%s/data%0d", tag, k), q_words[k][31:0], mem[(base + k) % DEPTH]);
            chk($sformatf("%s/last%0d", tag, k), q_words[k][32], (k == cnt - 1) ? 1 : 0);
        end
        chk({tag, "/n_reads"}, n_reads, cnt);
        for (int k = 0; k < q_addrs.size() && k < cnt; k++)
            chk($sformatf("%s/addr%0d", tag, k), q_addrs[k], (base + k) % DEPTH);
        chk({tag, "/n_done"}, n_done, 1);
        chk({tag, "/stable"}, stab_err, 0);
        chk({tag, "/after_done"}, post_err, 0);
        n_tests++;
        if (max_out > 2) begin
            n_fail++;
            $display("FAIL %s/outstanding: got %0d, expected at most 2", tag, max_out);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/done"}, done, 0);
        chk({tag, "/mem_read_en"}, mem_read_en, 0);
        chk({tag, "/out_valid"}, out_valid, 0);
        chk({tag, "/out_last"}, out_last, 0);
        chk({tag, "/mem_addr"}, mem_addr, 0);
        chk({tag, "/out_data"}, out_data, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int abort_err;
        int b, n;
        // base, cnt, mode, poke, exp_done, exp_busy0, first, last
        vecs[0] = '{0, 8, 0, -1, 10, 1, 32'h1000, 32'h1007};   // basic sweep
        vecs[1] = '{6, 4, 0, -1,  6, 1, 32'h1006, 32'h1001};   // wrap-around
        vecs[2] = '{2, 5, 1, -1, -1, 1, 32'h1002, 32'h1006};   // back-pressure
        vecs[3] = '{5, 0, 0, -1,  0, 0, 32'h0,    32'h0};      // zero count
        vecs[4] = '{0, 4, 0,  3,  6, 1, 32'h1000, 32'h1003};   // ignored start
        vecs[5] = '{7, 1, 0, -1,  3, 1, 32'h1007, 32'h1007};   // single word
        vecs[6] = '{1, 8, 3, -1, -1, 1, 32'h1001, 32'h1000};   // long stall
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + i;

        start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].base, vecs[i].cnt, vecs[i].mode, vecs[i].poke);
            verify($sformatf("vec%0d", i), vecs[i].base, vecs[i].cnt);
            if (vecs[i].exp_done >= 0)
                chk($sformatf("vec%0d/done_cycle", i), done_cyc, vecs[i].exp_done);
            chk($sformatf("vec%0d/busy_first", i), busy0, vecs[i].exp_busy0);
            if (vecs[i].cnt > 0 && q_words.size() == vecs[i].cnt) begin
                chk($sformatf("vec%0d/first", i), q_words[0][31:0], vecs[i].exp_first);
                chk($sformatf("vec%0d/lastword", i), q_words[vecs[i].cnt-1][31:0], vecs[i].exp_lastw);
            end
        end

        // Reset abort after two words have been delivered
        @(posedge clk); #1;
        start = 1'b1; base_addr = 3'd0; count = 4'd8; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        abort_err = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done || mem_read_en || out_valid || busy) abort_err++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || mem_read_en || out_valid || busy) abort_err++;
        end
        chk("abort/quiet", abort_err, 0);
        run_req(4, 3, 0, -1);
        verify("after_abort", 4, 3);
        chk("after_abort/done_cycle", done_cyc, 5);

        // Randomized requests against the reference model
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int r = 0; r < 20; r++) begin
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(0, DEPTH);
            run_req(b, n, 2, -1);
            verify($sformatf("rand%0d", r), b, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
